// File: rtl/hba_arbiter.sv
// hba_arbiter
//   Round-robin arbiter and master-side multiplexer for the HBA bus. Grants the
//   shared bus to one master at a time, steers that master's address, control
//   and write data onto the shared lines, and revokes a grant that is held for
//   too long.
//
// Ports
//   hba_clk           bus clock
//   hba_reset         synchronous active-high reset
//   master_request    per-master bus request, bit i = master i
//   master_abus_in    packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   master_rnw_in     per-master read-not-write
//   master_select_in  per-master transfer-in-progress
//   master_dbus_in    packed write data, master i at [i*DBUS_WIDTH +: DBUS_WIDTH]
//   hba_mgrant        registered one-hot-or-zero grant
//   hba_abus          shared address (zero when nobody owns the bus)
//   hba_rnw           shared read-not-write
//   hba_select        shared select
//   hba_dbus_w        shared write data
//   arb_timeout       one-cycle pulse when the watchdog revokes a grant
//
// state   | meaning
// IDLE    | bus free, grant the next eligible requester in round-robin order
// GRANT   | one master owns the bus, watchdog counting
// HOLDOFF | one forced idle cycle after a release, may grant on its exit edge

module hba_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 12,
    parameter int DBUS_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              hba_clk,
    input  logic                              hba_reset,
    input  logic [NUM_MASTERS-1:0]            master_request,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] master_abus_in,
    input  logic [NUM_MASTERS-1:0]            master_rnw_in,
    input  logic [NUM_MASTERS-1:0]            master_select_in,
    input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] master_dbus_in,
    output logic [NUM_MASTERS-1:0]            hba_mgrant,
    output logic [ADDR_WIDTH-1:0]             hba_abus,
    output logic                              hba_rnw,
    output logic                              hba_select,
    output logic [DBUS_WIDTH-1:0]             hba_dbus_w,
    output logic                              arb_timeout
);

    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLDOFF
    } state_t;

    state_t                 state, state_n;
    logic [NUM_MASTERS-1:0] grant_n;
    logic [PTR_W-1:0]       owner, owner_n;
    logic [PTR_W-1:0]       rr_ptr, rr_ptr_n;
    logic [NUM_MASTERS-1:0] blocked, blocked_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   timeout_n;

    logic [NUM_MASTERS-1:0] eligible;
    logic [PTR_W-1:0]       pick;
    logic [PTR_W-1:0]       owner_succ;

    // First eligible master at or above ptr, wrapping around.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] elig,
                                                 input logic [PTR_W-1:0]       ptr);
        logic [PTR_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = (int'(ptr) + k) % NUM_MASTERS;
            if (!found && elig[idx]) begin
                sel   = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign eligible   = master_request & ~blocked;
    assign pick       = rr_pick(eligible, rr_ptr);
    assign owner_succ = (owner == PTR_LAST) ? '0 : owner + PTR_W'(1);

    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            state       <= IDLE;
            hba_mgrant  <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            blocked     <= '0;
            cnt         <= '0;
            arb_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            hba_mgrant  <= grant_n;
            owner       <= owner_n;
            rr_ptr      <= rr_ptr_n;
            blocked     <= blocked_n;
            cnt         <= cnt_n;
            arb_timeout <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = hba_mgrant;
        owner_n   = owner;
        rr_ptr_n  = rr_ptr;
        // A blocked master is released as soon as it lets go of its request.
        blocked_n = blocked & master_request;
        cnt_n     = cnt;
        timeout_n = 1'b0;

        case (state)
            IDLE, HOLDOFF: begin
                grant_n = '0;
                state_n = IDLE;
                if (|eligible) begin
                    grant_n = NUM_MASTERS'(1) << pick;
                    owner_n = pick;
                    cnt_n   = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                // Release wins over a watchdog expiry landing on the same cycle.
                if (!master_request[owner]) begin
                    grant_n  = '0;
                    rr_ptr_n = owner_succ;
                    state_n  = HOLDOFF;
                end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
                    grant_n          = '0;
                    timeout_n        = 1'b1;
                    blocked_n[owner] = 1'b1;
                    rr_ptr_n         = owner_succ;
                    state_n          = HOLDOFF;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Grant is one-hot or zero, so OR-ing the masked fields is a clean mux
    // and drives all-zero when nobody owns the bus.
    always_comb begin
        hba_abus   = '0;
        hba_rnw    = 1'b0;
        hba_select = 1'b0;
        hba_dbus_w = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hba_mgrant[i]) begin
                hba_abus   = hba_abus   | master_abus_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                hba_rnw    = hba_rnw    | master_rnw_in[i];
                hba_select = hba_select | master_select_in[i];
                hba_dbus_w = hba_dbus_w | master_dbus_in[i*DBUS_WIDTH +: DBUS_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_hba_arbiter.sv
// tb_hba_arbiter
//   Directed bench for hba_arbiter with two masters and an 8-cycle watchdog.
//   Inputs change 1 ns after a rising edge; outputs are checked at that same
//   point, so every check sees the result of the edge just taken.

module tb_hba_arbiter;

    logic        hba_clk;
    logic        hba_reset;
    logic [1:0]  master_request;
    logic [23:0] master_abus_in;
    logic [1:0]  master_rnw_in;
    logic [1:0]  master_select_in;
    logic [15:0] master_dbus_in;
    logic [1:0]  hba_mgrant;
    logic [11:0] hba_abus;
    logic        hba_rnw;
    logic        hba_select;
    logic [7:0]  hba_dbus_w;
    logic        arb_timeout;

    logic [11:0] abus0, abus1;
    logic [7:0]  dbus0, dbus1;

    int total;
    int bad;

    assign master_abus_in = {abus1, abus0};
    assign master_dbus_in = {dbus1, dbus0};

    hba_arbiter #(
        .NUM_MASTERS   (2),
        .ADDR_WIDTH    (12),
        .DBUS_WIDTH    (8),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .hba_clk         (hba_clk),
        .hba_reset       (hba_reset),
        .master_request  (master_request),
        .master_abus_in  (master_abus_in),
        .master_rnw_in   (master_rnw_in),
        .master_select_in(master_select_in),
        .master_dbus_in  (master_dbus_in),
        .hba_mgrant      (hba_mgrant),
        .hba_abus        (hba_abus),
        .hba_rnw         (hba_rnw),
        .hba_select      (hba_select),
        .hba_dbus_w      (hba_dbus_w),
        .arb_timeout     (arb_timeout)
    );

    initial hba_clk = 1'b0;
    always #5 hba_clk = ~hba_clk;

    task automatic step();
        @(posedge hba_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic [1:0] g, input logic [11:0] a,
                             input logic r, input logic s, input logic [7:0] d);
        check({tag, "_grant"}, 32'(hba_mgrant), 32'(g));
        check({tag, "_abus"},  32'(hba_abus),   32'(a));
        check({tag, "_rnw"},   32'(hba_rnw),    32'(r));
        check({tag, "_sel"},   32'(hba_select), 32'(s));
        check({tag, "_dbus"},  32'(hba_dbus_w), 32'(d));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        hba_reset        = 1'b1;
        master_request   = 2'b00;
        abus0            = 12'h000;
        abus1            = 12'h000;
        dbus0            = 8'h00;
        dbus1            = 8'h00;
        master_rnw_in    = 2'b00;
        master_select_in = 2'b00;

        step();
        step();
        check_bus("reset", 2'b00, 12'h000, 1'b0, 1'b0, 8'h00);
        check("reset_tmo", 32'(arb_timeout), 32'd0);
        hba_reset = 1'b0;
        step();

        // single request from master 0
        abus0            = 12'h305;
        dbus0            = 8'h5A;
        master_rnw_in    = 2'b01;
        master_select_in = 2'b01;
        master_request   = 2'b01;
        step();
        check_bus("single", 2'b01, 12'h305, 1'b1, 1'b1, 8'h5A);
        step();
        check("single_hold", 32'(hba_mgrant), 32'h1);
        master_request = 2'b00;
        step();
        check_bus("single_drop", 2'b00, 12'h000, 1'b0, 1'b0, 8'h00);
        step();
        check("idle_grant", 32'(hba_mgrant), 32'h0);

        // master 1 drives everything while never granted
        abus1            = 12'hFFF;
        dbus1            = 8'hAA;
        master_rnw_in    = 2'b10;
        master_select_in = 2'b10;
        step();
        check_bus("iso_idle", 2'b00, 12'h000, 1'b0, 1'b0, 8'h00);

        // master 0 owns, master 1 still driving: only master 0's fields seen
        abus0            = 12'h123;
        dbus0            = 8'h11;
        master_select_in = 2'b11;
        master_request   = 2'b01;
        step();
        check_bus("iso_m0", 2'b01, 12'h123, 1'b0, 1'b1, 8'h11);

        // master 1 requests while master 0 owns: no pre-emption
        master_request = 2'b11;
        step();
        check("nopre_1", 32'(hba_mgrant), 32'h1);
        step();
        check("nopre_2", 32'(hba_mgrant), 32'h1);
        master_request = 2'b10;
        step();
        check("nopre_hold", 32'(hba_mgrant), 32'h0);
        step();
        check_bus("nopre_m1", 2'b10, 12'hFFF, 1'b1, 1'b1, 8'hAA);

        // round robin: each owner drops after 3 granted cycles, re-requests at once
        master_request = 2'b11;
        step();
        check("rr_m1_c2", 32'(hba_mgrant), 32'h2);
        step();
        check("rr_m1_c3", 32'(hba_mgrant), 32'h2);
        master_request = 2'b01;
        step();
        check("rr_hold1", 32'(hba_mgrant), 32'h0);
        master_request = 2'b11;
        step();
        check("rr_m0", 32'(hba_mgrant), 32'h1);
        step();
        step();
        check("rr_m0_c3", 32'(hba_mgrant), 32'h1);
        master_request = 2'b10;
        step();
        check("rr_hold2", 32'(hba_mgrant), 32'h0);
        master_request = 2'b11;
        step();
        check("rr_m1", 32'(hba_mgrant), 32'h2);
        master_request = 2'b00;
        step();
        step();
        check("rr_idle", 32'(hba_mgrant), 32'h0);

        // watchdog: master 0 holds its request past 8 granted cycles
        master_request = 2'b01;
        step();
        check("wd_grant", 32'(hba_mgrant), 32'h1);
        for (int k = 2; k <= 8; k++) begin
            step();
            check($sformatf("wd_held_c%0d", k), 32'(hba_mgrant), 32'h1);
            check($sformatf("wd_tmo_c%0d", k), 32'(arb_timeout), 32'd0);
        end
        step();
        check("wd_revoke", 32'(hba_mgrant), 32'h0);
        check("wd_pulse", 32'(arb_timeout), 32'd1);
        step();
        check("wd_pulse_end", 32'(arb_timeout), 32'd0);
        check("wd_blocked1", 32'(hba_mgrant), 32'h0);
        step();
        step();
        check("wd_blocked2", 32'(hba_mgrant), 32'h0);
        master_request = 2'b00;
        step();
        master_request = 2'b01;
        step();
        check("wd_regrant", 32'(hba_mgrant), 32'h1);

        // release on the very cycle the watchdog would fire: plain release
        for (int k = 2; k <= 8; k++) step();
        check("edge_c8", 32'(hba_mgrant), 32'h1);
        master_request = 2'b00;
        step();
        check("edge_drop", 32'(hba_mgrant), 32'h0);
        check("edge_no_tmo", 32'(arb_timeout), 32'd0);
        master_request = 2'b01;
        step();
        check("edge_not_blocked", 32'(hba_mgrant), 32'h1);

        // reset while master 1 owns the bus
        master_request = 2'b10;
        step();
        step();
        check("rst_pre_m1", 32'(hba_mgrant), 32'h2);
        master_request = 2'b11;
        hba_reset      = 1'b1;
        step();
        check("rst_grant", 32'(hba_mgrant), 32'h0);
        check("rst_tmo", 32'(arb_timeout), 32'd0);
        step();
        hba_reset = 1'b0;
        step();
        check("rst_ptr0", 32'(hba_mgrant), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
